// File: rtl/approx_adder_pkg.sv
// Shared types and helpers for the pipelined approximate ripple-carry adder.
// Holds the mode encoding, the k clamp and the single-bit adder cell.
package approx_adder_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_CONST = 2'd1,
        MODE_LOA   = 2'd2,
        MODE_TRUNC = 2'd3
    } mode_e;

    // Effective number of approximate LSBs; exact mode never approximates.
    function automatic int clamp_k(input mode_e mode, input int k, input int max_k);
        int r;
        if (mode == MODE_EXACT) begin
            r = 0;
        end else if (k > max_k) begin
            r = max_k;
        end else begin
            r = k;
        end
        return r;
    endfunction

    // Returns {cout, s}. Approximate cells ignore the incoming carry; only the
    // top approximate bit of LOA may launch a carry into the exact part.
    function automatic logic [1:0] approx_cell(
        input logic  a,
        input logic  b,
        input logic  cin,
        input mode_e mode,
        input logic  is_approx,
        input logic  is_msb_approx
    );
        logic [1:0] r;
        r = {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
        if (is_approx) begin
            case (mode)
                MODE_CONST: r = 2'b01;
                MODE_LOA:   r = {is_msb_approx & a & b, a | b};
                MODE_TRUNC: r = 2'b00;
                default:    r = {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/approx_rc_segment.sv
// Combinational carry-chain segment of SEG_W bits starting at bit 'offset'
// of the full word; bits below k use the selected approximate cell.
module approx_rc_segment
    import approx_adder_pkg::*;
#(
    parameter int SEG_W = 8,
    parameter int KW    = 4,
    parameter int OFF_W = 5
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    input  mode_e            mode,
    input  logic [KW-1:0]    k,
    input  logic [OFF_W-1:0] offset,
    output logic [SEG_W-1:0] sum,
    output logic             cout
);

    always_comb begin
        logic       c;
        logic [1:0] r;
        int         idx;
        c   = cin;
        r   = '0;
        idx = 0;
        sum = '0;
        for (int i = 0; i < SEG_W; i++) begin
            idx    = int'(offset) + i;
            r      = approx_cell(a[i], b[i], c, mode, idx < int'(k), (idx + 1) == int'(k));
            sum[i] = r[0];
            c      = r[1];
        end
        cout = c;
    end

endmodule

// File: rtl/approx_rc_adder_pipe.sv
// Pipelined approximate ripple-carry adder: one carry segment per stage,
// valid/ready handshake with per-transaction mode and approximation depth.
module approx_rc_adder_pipe
    import approx_adder_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int STAGES     = 2,
    parameter int MAX_APPROX = 9,
    parameter int KW         = (MAX_APPROX > 0) ? $clog2(MAX_APPROX + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    input  logic [KW-1:0]    in_k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum
);

    localparam int C     = WIDTH / STAGES;
    localparam int OFF_W = $clog2(WIDTH) + 1;
    localparam int LAST  = STAGES - 1;

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] ld;

    // A stage may load when it, or any stage after it, is empty, or the output drains.
    always_comb begin
        ld = '0;
        for (int s = 0; s < STAGES; s++) begin
            ld[s] = out_ready;
            for (int j = s; j < STAGES; j++) begin
                if (!vld_p[j]) begin
                    ld[s] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (ld[s]) begin
                    vld_p[s] <= (s == 0) ? in_valid : vld_p[(s == 0) ? 0 : s - 1];
                end
            end
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : stg
        localparam int REM = WIDTH - s * C;

        logic [REM-1:0]   a_in;
        logic [REM-1:0]   b_in;
        logic [WIDTH-1:0] sum_in;
        logic             cy_in;
        mode_e            mode_in;
        logic [KW-1:0]    k_in;
        logic [C-1:0]     seg_s;
        logic             seg_c;
        logic [WIDTH-1:0] sum_q;
        logic             cy_q;

        // Stage boundary: stage 0 takes the input port, later stages the previous register.
        if (s == 0) begin : g_src
            assign a_in    = in_a;
            assign b_in    = in_b;
            assign sum_in  = '0;
            assign cy_in   = 1'b0;
            assign mode_in = mode_e'(in_mode);
            assign k_in    = KW'(clamp_k(mode_e'(in_mode), int'(in_k), MAX_APPROX));
        end else begin : g_src
            assign a_in    = stg[s-1].g_ops.a_q;
            assign b_in    = stg[s-1].g_ops.b_q;
            assign sum_in  = stg[s-1].sum_q;
            assign cy_in   = stg[s-1].cy_q;
            assign mode_in = stg[s-1].g_ops.mode_q;
            assign k_in    = stg[s-1].g_ops.k_q;
        end

        approx_rc_segment #(
            .SEG_W (C),
            .KW    (KW),
            .OFF_W (OFF_W)
        ) u_seg (
            .a      (a_in[C-1:0]),
            .b      (b_in[C-1:0]),
            .cin    (cy_in),
            .mode   (mode_in),
            .k      (k_in),
            .offset (OFF_W'(s * C)),
            .sum    (seg_s),
            .cout   (seg_c)
        );

        always_ff @(posedge clk) begin
            if (ld[s]) begin
                sum_q <= sum_in | (WIDTH'(seg_s) << (s * C));
                cy_q  <= seg_c;
            end
        end

        // Only stages with a successor carry the unconsumed operand bits and config.
        if (s < LAST) begin : g_ops
            logic [REM-C-1:0] a_q;
            logic [REM-C-1:0] b_q;
            mode_e            mode_q;
            logic [KW-1:0]    k_q;

            always_ff @(posedge clk) begin
                if (ld[s]) begin
                    a_q    <= a_in[REM-1:C];
                    b_q    <= b_in[REM-1:C];
                    mode_q <= mode_in;
                    k_q    <= k_in;
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = vld_p[LAST];
    assign out_sum   = vld_p[LAST] ? {stg[LAST].cy_q, stg[LAST].sum_q} : '0;

endmodule

// File: tb/tb_approx_rc_adder_pipe.sv
// Scoreboard bench for approx_rc_adder_pipe: expected sums are queued at
// acceptance and compared by an independent output monitor.
module tb_approx_rc_adder_pipe;

    localparam int WIDTH      = 16;
    localparam int STAGES     = 2;
    localparam int MAX_APPROX = 9;
    localparam int KW         = $clog2(MAX_APPROX + 1);
    localparam int SW         = WIDTH + 1;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_a      = '0;
    logic [WIDTH-1:0] in_b      = '0;
    logic [1:0]       in_mode   = '0;
    logic [KW-1:0]    in_k      = '0;
    logic             in_ready;
    logic             out_valid;
    logic [SW-1:0]    out_sum;

    int            checks   = 0;
    int            failures = 0;
    logic [SW-1:0] exp_q[$];
    bit            rand_rdy = 1'b0;

    approx_rc_adder_pipe #(
        .WIDTH      (WIDTH),
        .STAGES     (STAGES),
        .MAX_APPROX (MAX_APPROX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    always #5 clk = ~clk;

    // Reference: exact high part shifted back over an approximated low field.
    function automatic logic [SW-1:0] ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [1:0] m, input int kin);
        int     k;
        longint mask, cy, hi, lo;
        k = (m == 2'd0) ? 0 : ((kin > MAX_APPROX) ? MAX_APPROX : kin);
        if (k == 0) return SW'(longint'(a) + longint'(b));
        mask = (longint'(1) << k) - 1;
        cy   = (m == 2'd2) ? ((longint'(a) >> (k - 1)) & (longint'(b) >> (k - 1)) & 1) : 0;
        hi   = ((longint'(a) >> k) + (longint'(b) >> k) + cy) << k;
        case (m)
            2'd1:    lo = mask;
            2'd2:    lo = (longint'(a) | longint'(b)) & mask;
            default: lo = 0;
        endcase
        return SW'(hi + lo);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one transaction starting just after a rising edge; returns the stall count.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] m,
                        input logic [KW-1:0] k, input logic [SW-1:0] req, output int waits);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_mode = m;
        in_k = k;
        waits = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(req);
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            waits++;
            if (waits > 300) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=in_ready_low required=accept");
                break;
            end
        end
        in_valid = 1'b0;
        in_a = WIDTH'($urandom);
        in_b = WIDTH'($urandom);
        in_mode = 2'($urandom);
        in_k = KW'($urandom);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=0x%0h required=no_output", out_sum);
            end else begin
                check("out_sum", 32'(out_sum), 32'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int               w, lat, nout, n;
        logic [WIDTH-1:0] a, b;
        logic [1:0]       m;
        logic [KW-1:0]    k;
        logic [WIDTH-1:0] ta [3];
        logic [WIDTH-1:0] tb [3];
        logic [1:0]       tm [3];
        logic [KW-1:0]    tk [3];
        logic [SW-1:0]    te [3];
        ta = '{16'h1234, 16'h0008, 16'h1234};
        tb = '{16'h4321, 16'h0008, 16'h0F0F};
        tm = '{2'd0, 2'd2, 2'd3};
        tk = '{4'd0, 4'd4, 4'd8};
        te = '{17'h05555, 17'h00018, 17'h02100};

        #1;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_sum", 32'(out_sum), 0);
        tick(3);
        rst_n = 1'b1;
        check("post_reset_in_ready", 32'(in_ready), 1);
        check("post_reset_out_valid", 32'(out_valid), 0);

        out_ready = 1'b1;
        send(16'hFFFF, 16'h0001, 2'd1, 4'd9, 17'h0FFFF, w);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick(1);
            lat++;
        end
        check("latency", 32'(lat), 32'(STAGES));
        send(16'hFFFF, 16'h0001, 2'd0, 4'd9, 17'h10000, w);
        send(16'h0008, 16'h0008, 2'd2, 4'd4, 17'h00018, w);
        send(16'h1234, 16'h0F0F, 2'd3, 4'd8, 17'h02100, w);
        send(16'h0000, 16'h0000, 2'd1, 4'd15, 17'h001FF, w);
        send(16'h0100, 16'h0100, 2'd2, 4'd9, 17'h00300, w);
        for (int i = 0; i < 4; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            send(a, b, 2'(i), 4'd0, {1'b0, a} + {1'b0, b}, w);
        end
        tick(STAGES + 3);

        out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) send(ta[i % 3], tb[i % 3], tm[i % 3], tk[i % 3], te[i % 3], w);
        check("full_in_ready", 32'(in_ready), 0);
        fork
            begin
                for (int i = STAGES; i < 3; i++) send(ta[i], tb[i], tm[i], tk[i], te[i], w);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    check("stall_in_ready", 32'(in_ready), 0);
                    check("stall_out_valid", 32'(out_valid), 1);
                    tick(1);
                end
                out_ready = 1'b1;
            end
        join
        tick(STAGES + 3);
        check("stall_drained", 32'(exp_q.size()), 0);

        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            m = 2'($urandom);
            k = KW'($urandom);
            send(a, b, m, k, ref_model(a, b, m, int'(k)), w);
            check("no_bubble", 32'(w), 0);
        end

        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 4) == 0) tick(1);
            case ($urandom_range(0, 5))
                0:       begin a = '1; b = WIDTH'($urandom); end
                1:       begin a = '0; b = '0; end
                default: begin a = WIDTH'($urandom); b = WIDTH'($urandom); end
            endcase
            m = 2'($urandom);
            k = KW'($urandom);
            send(a, b, m, k, ref_model(a, b, m, int'(k)), w);
        end
        rand_rdy = 1'b0;
        tick(1);
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick(1);
            n++;
        end
        check("random_drained", 32'(exp_q.size()), 0);

        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            send(a, b, 2'd0, 4'd0, ref_model(a, b, 2'd0, 0), w);
        end
        rst_n = 1'b0;
        #1;
        check("midflight_out_valid", 32'(out_valid), 0);
        check("midflight_out_sum", 32'(out_sum), 0);
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        check("after_reset_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        nout = 0;
        repeat (8) begin
            tick(1);
            if (out_valid) nout++;
        end
        check("no_ghost_outputs", 32'(nout), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
